// File: rtl/shared_pipe_arbiter_dataless_pkg.sv
// Shared types and constants for the dataless shared-pipe arbiter.
// Builds with SHARED_PIPE_ARB_FIXED_PRIO_EN select fixed-priority arbitration.
package shared_pipe_arbiter_dataless_pkg;

    localparam int NUM_SLOTS_DEF = 4;
    localparam int NUM_REQ_DEF   = 2;

    // Tag width is never zero, so a two-requester build still carries a 1-bit tag.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int TAG_W_DEF = tag_w(NUM_REQ_DEF);

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
    } slot_t;

endpackage

// File: rtl/shared_pipe_tag_shift_reg.sv
// Chain of {valid, tag} slots advancing as one unit under a shared enable.
// The last slot is the head presented to the output decode.
module shared_pipe_tag_shift_reg
    import shared_pipe_arbiter_dataless_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int TAG_W     = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             head_valid,
    output logic [TAG_W-1:0] head_tag
);

    // Same record layout as slot_t, sized for this instance's tag width.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } rec_t;

    rec_t slot_q [NUM_SLOTS];
    rec_t slot_d [NUM_SLOTS];

    always_comb begin
        slot_d[0].valid = in_valid;
        slot_d[0].tag   = in_tag;
        for (int k = 1; k < NUM_SLOTS; k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    assign head_valid = slot_q[NUM_SLOTS-1].valid;
    assign head_tag   = slot_q[NUM_SLOTS-1].tag;

endmodule

// File: rtl/shared_pipe_arbiter_dataless.sv
// Dataless N-requester arbiter feeding one shared fixed-latency pipeline.
// Round-robin by default; SHARED_PIPE_ARB_FIXED_PRIO_EN selects fixed priority.
module shared_pipe_arbiter_dataless
    import shared_pipe_arbiter_dataless_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int NUM_REQ   = NUM_REQ_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] ins_valid,
    output logic [NUM_REQ-1:0] ins_ready,
    output logic [NUM_REQ-1:0] outs_valid,
    input  logic [NUM_REQ-1:0] outs_ready
);

    localparam int TAG_W = tag_w(NUM_REQ);

    logic               head_valid;
    logic [TAG_W-1:0]   head_tag;
    logic               en;
    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   grant_idx;
    logic               grant_any;

    // A stalled head freezes the whole chain, so every requester waits on it.
    assign en = ~head_valid | outs_ready[head_tag];

`ifdef SHARED_PIPE_ARB_FIXED_PRIO_EN
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && ins_valid[k]) begin
                grant_any = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = TAG_W'(k);
            end
        end
    end
`else
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_any && ins_valid[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = TAG_W'(idx);
            end
        end
    end

    // Pointer moves past the winner only when its token is actually taken.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (en && grant_any) begin
            rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign ins_ready = {NUM_REQ{en}} & grant;

    always_comb begin
        outs_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            outs_valid[i] = head_valid && (head_tag == TAG_W'(i));
        end
    end

    shared_pipe_tag_shift_reg #(
        .NUM_SLOTS (NUM_SLOTS),
        .TAG_W     (TAG_W)
    ) u_slots (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (grant_any),
        .in_tag     (grant_idx),
        .head_valid (head_valid),
        .head_tag   (head_tag)
    );

endmodule

// File: tb/tb_shared_pipe_arbiter_dataless.sv
// Directed scenarios plus a token scoreboard for shared_pipe_arbiter_dataless.
// Expectations switch with SHARED_PIPE_ARB_FIXED_PRIO_EN where arbitration differs.
module tb_shared_pipe_arbiter_dataless;

    localparam int NS = 4;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] ins_valid = '0;
    logic [NR-1:0] ins_ready;
    logic [NR-1:0] outs_valid;
    logic [NR-1:0] outs_ready = '0;

    typedef struct {
        int tag;
        int acc;
    } sb_t;

    sb_t sbq[$];
    int  checks  = 0;
    int  errors  = 0;
    int  cyc     = 0;
    bit  lat_chk = 1'b0;

    shared_pipe_arbiter_dataless #(.NUM_SLOTS(NS), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Scoreboard sample on settled inputs, then one full clock.
    task automatic adv();
        for (int i = 0; i < NR; i++) begin
            if (outs_valid[i] && outs_ready[i]) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: output tag %0d, expected no token", i);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    if (i !== e.tag) begin
                        errors++;
                        $display("FAIL sb_tag: got tag %0d, expected %0d", i, e.tag);
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc - e.acc !== NS) begin
                            errors++;
                            $display("FAIL sb_latency: got %0d cycles, expected %0d", cyc - e.acc, NS);
                        end
                    end
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (ins_valid[i] && ins_ready[i]) sbq.push_back('{tag: i, acc: cyc});
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        ins_valid  = '0;
        outs_ready = '0;
        rst        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sbq.size() !== 0) begin
            errors++;
            $display("FAIL %s: %0d tokens left, expected 0", name, sbq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ins_valid = 2'b11; outs_ready = 2'b11;
        #1;
        checks++;
        if (outs_valid !== 2'b00) begin errors++; $display("FAIL rst_outs: got %b, expected 00", outs_valid); end
        checks++;
        if (ins_ready !== 2'b01) begin errors++; $display("FAIL rst_rdy11: got %b, expected 01", ins_ready); end
        ins_valid = 2'b10;
        #1;
        checks++;
        if (ins_ready !== 2'b10) begin errors++; $display("FAIL rst_rdy10: got %b, expected 10", ins_ready); end
        ins_valid = 2'b11;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs_valid !== 2'b00) begin errors++; $display("FAIL rst_hold: got %b, expected 00", outs_valid); end
        ins_valid = '0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        lat_chk = 1'b1;
        do_reset();
        ins_valid = 2'b01; outs_ready = 2'b11;
        #1;
        checks++;
        if (ins_ready !== 2'b01) begin errors++; $display("FAIL single_acc: got %b, expected 01", ins_ready); end
        adv();
        ins_valid = '0;
        for (int c = 1; c <= 5; c++) begin
            logic [NR-1:0] exp_o;
            exp_o = (c == NS) ? 2'b01 : 2'b00;
            #1;
            checks++;
            if (outs_valid !== exp_o) begin errors++; $display("FAIL single_out c%0d: got %b, expected %b", c, outs_valid, exp_o); end
            adv();
        end
        check_sb_empty("single_sb");
    endtask

    task automatic test_contention();
        lat_chk = 1'b1;
        do_reset();
        outs_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            logic [NR-1:0] exp_r;
`ifdef SHARED_PIPE_ARB_FIXED_PRIO_EN
            exp_r = 2'b01;
`else
            exp_r = (c % 2 == 1) ? 2'b10 : 2'b01;
`endif
            ins_valid = 2'b11;
            #1;
            checks++;
            if (ins_ready !== exp_r) begin errors++; $display("FAIL cont_grant c%0d: got %b, expected %b", c, ins_ready, exp_r); end
            adv();
        end
        ins_valid = '0;
        for (int c = 4; c <= 8; c++) begin
            logic [NR-1:0] exp_o;
`ifdef SHARED_PIPE_ARB_FIXED_PRIO_EN
            exp_o = (c < 8) ? 2'b01 : 2'b00;
`else
            exp_o = (c == 8) ? 2'b00 : ((c % 2 == 1) ? 2'b10 : 2'b01);
`endif
            #1;
            checks++;
            if (outs_valid !== exp_o) begin errors++; $display("FAIL cont_out c%0d: got %b, expected %b", c, outs_valid, exp_o); end
            adv();
        end
        check_sb_empty("cont_sb");
    endtask

    task automatic fill_onehot(input int n);
        for (int c = 0; c < n; c++) begin
            ins_valid = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (ins_ready !== ins_valid) begin errors++; $display("FAIL fill_grant c%0d: got %b, expected %b", c, ins_ready, ins_valid); end
            adv();
        end
        ins_valid = '0;
    endtask

    task automatic test_stall();
        logic [NR-1:0] drain [5];
        drain = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        lat_chk = 1'b0;
        do_reset();
        outs_ready = 2'b10;
        fill_onehot(4);
        ins_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (outs_valid !== 2'b01) begin errors++; $display("FAIL stall_out c%0d: got %b, expected 01", c, outs_valid); end
            checks++;
            if (ins_ready !== 2'b00) begin errors++; $display("FAIL stall_rdy c%0d: got %b, expected 00", c, ins_ready); end
            adv();
        end
        ins_valid = '0; outs_ready = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (outs_valid !== drain[c]) begin errors++; $display("FAIL stall_drain c%0d: got %b, expected %b", c, outs_valid, drain[c]); end
            adv();
        end
        check_sb_empty("stall_sb");
    endtask

    task automatic test_full_overlap();
        logic [NR-1:0] drain [5];
        drain = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
        lat_chk = 1'b0;
        do_reset();
        outs_ready = 2'b00;
        fill_onehot(4);
        ins_valid = 2'b10;
        #1;
        checks++;
        if (ins_ready !== 2'b00) begin errors++; $display("FAIL full_rdy: got %b, expected 00", ins_ready); end
        adv();
        outs_ready = 2'b11;
        #1;
        checks++;
        if (outs_valid !== 2'b01) begin errors++; $display("FAIL ovl_out: got %b, expected 01", outs_valid); end
        checks++;
        if (ins_ready !== 2'b10) begin errors++; $display("FAIL ovl_rdy: got %b, expected 10", ins_ready); end
        adv();
        ins_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (outs_valid !== drain[c]) begin errors++; $display("FAIL ovl_drain c%0d: got %b, expected %b", c, outs_valid, drain[c]); end
            adv();
        end
        check_sb_empty("ovl_sb");
    endtask

    task automatic test_reset_mid();
        lat_chk = 1'b0;
        do_reset();
        outs_ready = 2'b00;
        fill_onehot(3);
        adv();
        #1;
        checks++;
        if (outs_valid !== 2'b01) begin errors++; $display("FAIL mid_pre: got %b, expected 01", outs_valid); end
        rst = 1'b0;
        #1;
        checks++;
        if (outs_valid !== 2'b00) begin errors++; $display("FAIL mid_async: got %b, expected 00", outs_valid); end
        #2;
        rst = 1'b1;
        sbq.delete();
        outs_ready = 2'b11;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (outs_valid !== 2'b00) begin errors++; $display("FAIL mid_after c%0d: got %b, expected 00", c, outs_valid); end
            adv();
        end
        check_sb_empty("mid_sb");
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_full_overlap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
